// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage
//
// Owns the fetch PC and issues one word read at a time to instruction memory.
// Returned words are buffered with their addresses in a small circular queue.
// The queue head drives if_pc/if_ins into the IF/ID register.
//
// Parameters
//   RESET_PC  fetch address after reset
//   QDEPTH    instruction queue entries, 1..4
//
// Ports
//   clk              clock, all state updates on rising edge
//   rst              asynchronous reset, active low (0 = reset)
//   pause            pipeline stall: IF/ID holds, queue head is not popped
//   branch_flag_i    redirect request from ID (honoured only when pause=0)
//   branch_target_i  redirect word address
//   vmem_pause_i     MEM stage owns memory: no new read is issued
//   imem_req_o       read request, held until acked
//   imem_addr_o      read word address, stable while imem_req_o=1
//   imem_ack_i       read done, imem_data_i valid this cycle
//   imem_data_i      read data
//   if_pc            PC of the presented instruction (0 when queue empty)
//   if_ins           presented instruction (NOP 16'h0800 when queue empty)
//
// Optional feature (macro IF_FETCH_STATS_EN)
//   Adds output stall_cnt_o [31:0]: a saturating count of cycles in which
//   pause=0 and the queue is empty, i.e. a bubble goes into IF/ID.
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        branch_flag_i,
  input  logic [15:0] branch_target_i,
  input  logic        vmem_pause_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] if_pc,
  output logic [15:0] if_ins
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  localparam logic [2:0]  QDEPTH_C = 3'(QDEPTH);
  localparam logic [1:0]  PTR_LAST = 2'(QDEPTH - 1);
  localparam logic [15:0] NOP      = 16'h0800;

  state_t      state_reg, state_next;
  logic [15:0] fetch_pc_reg, fetch_pc_next;
  logic        req_reg, req_next;
  logic [15:0] addr_reg, addr_next;
  logic [1:0]  rd_ptr_reg, rd_ptr_next;
  logic [1:0]  wr_ptr_reg, wr_ptr_next;
  logic [2:0]  count_reg, count_next;
  logic [31:0] entries [0:3];
  logic [31:0] head;

  logic branch_taken;
  logic do_pop;
  logic do_push;
  logic can_issue;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    branch_taken = branch_flag_i & ~pause;
    do_pop       = ~pause & (count_reg != 3'd0);
    // A word arriving in the redirect cycle belongs to the old path.
    do_push      = (state_reg == WAIT) & imem_ack_i & ~branch_taken;
    // Only IDLE can issue, so nothing is outstanding and count alone bounds
    // occupancy. No issue in a redirect cycle: fetch_pc is about to change.
    can_issue    = (state_reg == IDLE) & ~vmem_pause_i &
                   (count_reg < QDEPTH_C) & ~branch_taken;
  end

  // Fetch FSM: next state and memory request
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (can_issue) begin
          state_next = WAIT;
          req_next   = 1'b1;
          addr_next  = fetch_pc_reg;
        end
      end
      WAIT: begin
        if (imem_ack_i) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end else if (branch_taken) begin
          state_next = DROP;   // keep the request up, discard its data
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (branch_taken) begin
      fetch_pc_next = branch_target_i;
    end else if (do_push) begin
      fetch_pc_next = fetch_pc_reg + 16'd1;   // wraps FFFF -> 0000
    end
  end

  // Queue pointers: a redirect pops the delay-slot head and flushes the rest
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (branch_taken) begin
      rd_ptr_next = 2'd0;
      wr_ptr_next = 2'd0;
      count_next  = 3'd0;
    end else begin
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 3'd1;
        2'b01:   count_next = count_reg - 3'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_reg      <= 1'b0;
      addr_reg     <= 16'h0000;
      rd_ptr_reg   <= 2'd0;
      wr_ptr_reg   <= 2'd0;
      count_reg    <= 3'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Queue storage: {pc, instruction}. Slots at or beyond QDEPTH are never
  // addressed by the pointers and stay at their reset value.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [31:0] entry_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg <= 32'h0;
        end else if (do_push && (wr_ptr_reg == 2'(gi))) begin
          entry_reg <= {addr_reg, imem_data_i};
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign head        = entries[rd_ptr_reg];
  assign if_pc       = (count_reg != 3'd0) ? head[31:16] : 16'h0000;
  assign if_ins      = (count_reg != 3'd0) ? head[15:0]  : NOP;
  assign imem_req_o  = req_reg;
  assign imem_addr_o = addr_reg;

`ifdef IF_FETCH_STATS_EN
  logic [31:0] stall_cnt_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= 32'h0;
    end else if (~pause && (count_reg == 3'd0) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory responder with one-cycle ack latency, a
// scoreboard of expected {pc, ins} pairs filled as words are returned and
// drained as the stage presents them, plus a second instance built with
// RESET_PC=FFFF to observe address wrap.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic        branch_flag_i;
  logic [15:0] branch_target_i;
  logic        vmem_pause_i;
  logic        imem_ack_i;
  logic [15:0] imem_data_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] if_pc;
  logic [15:0] if_ins;

  logic        ack2;
  logic [15:0] data2;
  logic        req2;
  logic [15:0] addr2;
  logic [15:0] pc2;
  logic [15:0] ins2;

`ifdef IF_FETCH_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] stall_cnt2;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];
  logic [15:0] log2[$];
  logic [15:0] model_pc = 16'h0000;
  bit          drop_pend = 0;
  bit          mon_en = 0;
  bit          manual = 0;
  bit          man_ack = 0;
  bit          seen = 0;

  always #5 clk = ~clk;

  if_fetch u_dut (
    .clk(clk), .rst(rst), .pause(pause),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .vmem_pause_i(vmem_pause_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .if_pc(if_pc), .if_ins(if_ins)
`ifdef IF_FETCH_STATS_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  if_fetch #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .pause(1'b0),
    .branch_flag_i(1'b0), .branch_target_i(16'h0000),
    .vmem_pause_i(1'b0),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_data_i(data2),
    .if_pc(pc2), .if_ins(ins2)
`ifdef IF_FETCH_STATS_EN
    , .stall_cnt_o(stall_cnt2)
`endif
  );

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode 0: req && !ack, 1: ack, 2: req
  task automatic wait_for(input int mode, input string tag);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk); #2;
      case (mode)
        0:       hit = imem_req_o && !imem_ack_i;
        1:       hit = imem_ack_i;
        default: hit = imem_req_o;
      endcase
    end
    chk(tag, {31'b0, hit}, 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  // Memory responder for the main instance: ack one cycle after req is seen
  initial begin
    imem_ack_i  = 1'b0;
    imem_data_i = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (manual) begin
        imem_ack_i  = man_ack;
        imem_data_i = 16'hDEAD;
        seen        = 0;
      end else if (!rst) begin
        imem_ack_i = 1'b0;
        seen       = 0;
      end else if (imem_ack_i) begin
        imem_ack_i = 1'b0;
        seen       = 0;
      end else if (imem_req_o && seen) begin
        imem_ack_i  = 1'b1;
        imem_data_i = word_of(imem_addr_o);
      end else begin
        seen = imem_req_o;
      end
    end
  end

  // Responder for the wrap instance: ack in the same cycle as req
  initial begin
    ack2  = 1'b0;
    data2 = 16'h0000;
    forever begin
      @(posedge clk); #1;
      ack2  = rst && req2 && !ack2;
      data2 = ~addr2;
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  initial begin
    logic [31:0] e;
    bit bt;
    forever begin
      @(negedge clk);
      if (rst && ack2) log2.push_back(addr2);
      if (rst && mon_en) begin
        bt = branch_flag_i && !pause;
        if (sb.size() != 0) begin
          e = sb[0];
          chk("head_pc", {16'h0, if_pc}, {16'h0, e[31:16]});
          chk("head_ins", {16'h0, if_ins}, {16'h0, e[15:0]});
          if (!pause) begin
            $display("pop pc=%h ins=%h", if_pc, if_ins);
            void'(sb.pop_front());
          end
        end else begin
          chk("empty_pc", {16'h0, if_pc}, 32'h0);
          chk("empty_nop", {16'h0, if_ins}, 32'h0800);
        end
        if (bt) sb.delete();
        if (imem_ack_i && !manual) begin
          if (drop_pend || bt) begin
            drop_pend = 0;
          end else begin
            chk("req_addr", {16'h0, imem_addr_o}, {16'h0, model_pc});
            sb.push_back({model_pc, word_of(model_pc)});
            model_pc = model_pc + 16'd1;
          end
        end
        if (bt) begin
          if (imem_req_o && !imem_ack_i) drop_pend = 1;
          model_pc = branch_target_i;
        end
      end
    end
  end

  initial begin
    rst = 1'b0; pause = 1'b0; branch_flag_i = 1'b0;
    branch_target_i = 16'h0000; vmem_pause_i = 1'b0;
    step(3);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr", {16'h0, imem_addr_o}, 32'h0);
    chk("rst_pc", {16'h0, if_pc}, 32'h0);
    chk("rst_ins", {16'h0, if_ins}, 32'h0800);
    rst = 1'b1;
    mon_en = 1;

    // Free-running fetch, sequential addresses
    step(20);
    chk("wrap_a0", {16'h0, (log2.size() >= 2) ? log2[0] : 16'hDEAD}, 32'hFFFF);
    chk("wrap_a1", {16'h0, (log2.size() >= 2) ? log2[1] : 16'hDEAD}, 32'h0000);

    // Stall: queue fills, requests stop, head stable
    pause = 1'b1;
    step(8);
    chk("full_req", {31'b0, imem_req_o}, 32'd0);
    pause = 1'b0;

    // Redirect while a read is outstanding without ack -> dropped read
    wait_for(0, "wait_req_a");
    branch_flag_i = 1'b1; branch_target_i = 16'h0040;
    step(1);
    branch_flag_i = 1'b0;
    step(8);

    // Redirect in the ack cycle -> data discarded
    wait_for(1, "wait_ack_b");
    branch_flag_i = 1'b1; branch_target_i = 16'h0080;
    step(1);
    branch_flag_i = 1'b0;
    step(6);

    // Redirect held across pause: only taken once pause drops
    branch_flag_i = 1'b1; branch_target_i = 16'h00C0; pause = 1'b1;
    step(2);
    pause = 1'b0;
    step(1);
    branch_flag_i = 1'b0;
    step(8);

    // Memory steal while idle: no request
    wait_for(1, "wait_ack_v");
    vmem_pause_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("vmem_idle_req", {31'b0, imem_req_o}, 32'd0);
    end
    vmem_pause_i = 1'b0;

    // Memory steal during an outstanding read: read still completes
    wait_for(0, "wait_req_v");
    vmem_pause_i = 1'b1;
    step(3);
    chk("vmem_wait_done", {31'b0, imem_req_o}, 32'd0);
    vmem_pause_i = 1'b0;
    step(6);

    // Reset with a request pending; ack arriving around release is ignored
    manual = 1;
    wait_for(2, "wait_req_r");
    rst = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req_o}, 32'd0);
    chk("arst_addr", {16'h0, imem_addr_o}, 32'h0);
    chk("arst_ins", {16'h0, if_ins}, 32'h0800);
    sb.delete();
    model_pc  = 16'h0000;
    drop_pend = 0;
    man_ack   = 1;
    step(1);
    rst = 1'b1;
    man_ack = 0;
    step(1);
    manual = 0;
    step(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
